// File: rtl/sync_regram_mp.sv
// Multi-port zero-latency register RAM with highest-port-wins write priority and a sequential clear engine.
// Optional same-cycle write-to-read bypass: define SYNC_REGRAM_MP_BYPASS_EN.
module sync_regram_mp #(
    parameter int DATA_WIDTH     = 32,
    parameter int DATA_DEPTH     = 64,
    parameter int WR_PORTS       = 2,
    parameter int RD_PORTS       = 4,
    parameter int CLEAR_ON_RESET = 1,
    localparam int AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [WR_PORTS-1:0]                  we_i,
    input  logic [WR_PORTS-1:0][AW-1:0]          waddr_i,
    input  logic [WR_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic [RD_PORTS-1:0][AW-1:0]          raddr_i,
    output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
    input  logic                                 clear_i,
    output logic                                 busy_o
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          state_reg;
    logic [AW-1:0]   cnt_reg;
    logic            busy_reg;
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    localparam logic [AW-1:0] LAST_IDX = AW'(DATA_DEPTH - 1);

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < DATA_DEPTH;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt_reg   <= '0;
            busy_reg  <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (cnt_reg == LAST_IDX) begin
                        state_reg <= READY;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (clear_i) begin
                        state_reg <= CLEAR;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // The array has no reset; it is only touched while out of reset.
    // Later ports are assigned last so the highest index wins on a collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_reg == CLEAR) begin
                mem[cnt_reg] <= '0;
            end else begin
                for (int p = 0; p < WR_PORTS; p++) begin
                    if (we_i[p] && in_range(waddr_i[p])) begin
                        mem[waddr_i[p]] <= wdata_i[p];
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            logic [DATA_WIDTH-1:0] lane_data;

            always_comb begin
                lane_data = '0;
                if (state_reg == READY && in_range(raddr_i[gi])) begin
                    lane_data = mem[raddr_i[gi]];
`ifdef SYNC_REGRAM_MP_BYPASS_EN
                    for (int p = 0; p < WR_PORTS; p++) begin
                        if (we_i[p] && (waddr_i[p] == raddr_i[gi])) begin
                            lane_data = wdata_i[p];
                        end
                    end
`endif
                end
            end

            assign rdata_o[gi] = lane_data;
        end
    endgenerate

    assign busy_o = busy_reg;

endmodule
